// File: rtl/event_tagger_fifo_if.sv
// rtl/event_tagger_fifo_if.sv - readout handshake and status bundle for event_tagger_fifo
interface event_tagger_fifo_if #(
  parameter int CH         = 4,
  parameter int TW         = 36,
  parameter int DEPTH_LOG2 = 4,
  parameter int DROP_W     = 16
);
  localparam int RW = TW + CH + 3;

  logic [RW-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;
  logic [DEPTH_LOG2:0] fifo_level;
  logic [DROP_W-1:0]   drop_count;

  modport master (
    output out_data,
    output out_valid,
    output fifo_level,
    output drop_count,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  fifo_level,
    input  drop_count,
    output out_ready
  );
endinterface

// File: rtl/event_tagger_fifo.sv
// rtl/event_tagger_fifo.sv - time-stamps strobe edges, delta changes and timer wraps into a FWFT FIFO
module event_tagger_fifo #(
  parameter int CH         = 4,
  parameter int TW         = 36,
  parameter int DEPTH_LOG2 = 4,
  parameter int DROP_W     = 16,
  parameter int RW         = TW + CH + 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CH-1:0] strobe_channels,
  input  logic [CH-1:0] delta_channels,
  input  logic [CH-1:0] strobe_mask,
  input  logic          reset_counter,
  input  logic          counter_operate,
  input  logic          capture_operate,
  event_tagger_fifo_if.master rd
);
  localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  // free-running timer and input history
  logic [TW-1:0] timer;
  logic [CH-1:0] prev_strobe;
  logic [CH-1:0] old_delta;
  logic          lost_pending;

  // FIFO storage; head is a separate register so out_data holds when empty
  logic [RW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_next;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic [RW-1:0]         head;
  logic [DROP_W-1:0]     drops;

  // event selection and write decision
  logic [CH-1:0]   strobe_edge;
  logic            delta_evt;
  logic            timer_zero;
  logic            wrap_evt;
  logic            want_write;
  logic            strobe_clash;
  logic            pop;
  logic            push;
  logic            full_drop;
  logic [RW-1:0]   rec;
  logic [1:0]      drop_inc;
  logic [DROP_W:0] drop_sum;

  // Detect events, build the candidate record and decide push/pop/drop for this cycle
  always_comb begin
    strobe_edge  = strobe_channels & ~prev_strobe & strobe_mask;
    delta_evt    = (delta_channels != old_delta);
    timer_zero   = (timer == '0);
    wrap_evt     = timer_zero && counter_operate;
    want_write   = capture_operate && (delta_evt || (|strobe_edge) || wrap_evt);
    // a strobe edge hidden behind a delta record is lost, but only when capturing
    strobe_clash = capture_operate && delta_evt && (|strobe_edge);
    if (delta_evt) begin
      rec = {timer_zero, 1'b1, lost_pending, delta_channels, timer};
    end else begin
      rec = {timer_zero, 1'b0, lost_pending, strobe_edge, timer};
    end
    pop       = (level != '0) && rd.out_ready;
    // a full FIFO still accepts the push when its head leaves in the same cycle
    push      = want_write && ((level != FULL_LEVEL) || pop);
    full_drop = want_write && !push;
    drop_inc  = {1'b0, full_drop} + {1'b0, strobe_clash};
    drop_sum  = {1'b0, drops} + (DROP_W + 1)'(drop_inc);
    level_nxt = level + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
    rd_next   = rd_ptr + 1'b1;
  end

  // Timer: synchronous clear has priority over counting; wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (reset_counter) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(counter_operate);
    end
  end

  // Input history tracks every cycle, independent of capture or FIFO state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_strobe <= '0;
      old_delta   <= '0;
    end else begin
      prev_strobe <= strobe_channels;
      old_delta   <= delta_channels;
    end
  end

  // Loss bookkeeping: saturating drop counter and the flag carried by the next stored record
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drops        <= '0;
      lost_pending <= 1'b0;
    end else begin
      if (drop_sum[DROP_W]) begin
        drops <= '1;
      end else begin
        drops <= drop_sum[DROP_W-1:0];
      end
      if (push) begin
        lost_pending <= strobe_clash;
      end else if (full_drop) begin
        lost_pending <= 1'b1;
      end
    end
  end

  // FIFO storage write; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rec;
    end
  end

  // FIFO pointers, occupancy and the fall-through head register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      level <= level_nxt;
      if (pop) begin
        if (level > (DEPTH_LOG2 + 1)'(1)) begin
          head <= mem[rd_next];
        end else if (push) begin
          head <= rec;
        end
      end else if ((level == '0) && push) begin
        head <= rec;
      end
    end
  end

  assign rd.out_data   = head;
  assign rd.out_valid  = (level != '0);
  assign rd.fifo_level = level;
  assign rd.drop_count = drops;
endmodule

// File: tb/tb_event_tagger_fifo.sv
// tb/tb_event_tagger_fifo.sv - self-checking bench for event_tagger_fifo
module tb_event_tagger_fifo;
  localparam int CH = 4;
  localparam int TW = 8;
  localparam int DL = 2;
  localparam int DW = 4;
  localparam int RW = TW + CH + 3;
  localparam int DEPTH = 4;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] strobe_channels = '0;
  logic [CH-1:0] delta_channels = '0;
  logic [CH-1:0] strobe_mask = '0;
  logic          reset_counter = 1'b0;
  logic          counter_operate = 1'b0;
  logic          capture_operate = 1'b0;

  always #5 clk = ~clk;

  event_tagger_fifo_if #(.CH(CH), .TW(TW), .DEPTH_LOG2(DL), .DROP_W(DW)) bus ();

  event_tagger_fifo #(.CH(CH), .TW(TW), .DEPTH_LOG2(DL), .DROP_W(DW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .strobe_channels(strobe_channels),
    .delta_channels(delta_channels),
    .strobe_mask(strobe_mask),
    .reset_counter(reset_counter),
    .counter_operate(counter_operate),
    .capture_operate(capture_operate),
    .rd(bus)
  );

  int total = 0;
  int bad = 0;

  int            m_timer;
  logic [CH-1:0] m_prev;
  logic [CH-1:0] m_old;
  bit            m_lost;
  logic [RW-1:0] m_q[$];
  int            m_drop;
  logic [RW-1:0] m_head;

  typedef struct {
    logic [CH-1:0] s;
    logic [CH-1:0] d;
    logic [CH-1:0] m;
    bit            rc;
    bit            cop;
    bit            cap;
    bit            rdy;
    bit            ev;
    logic [RW-1:0] ed;
    int            el;
    int            edr;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] make_rec(input bit wrap, input bit typ, input bit lost,
                                             input logic [CH-1:0] ch, input int ts);
    logic [RW-1:0] r;
    r = '0;
    r[RW-1] = wrap;
    r[RW-2] = typ;
    r[RW-3] = lost;
    r[TW+CH-1:TW] = ch;
    r[TW-1:0] = ts[TW-1:0];
    return r;
  endfunction

  task automatic model_reset();
    m_timer = 0;
    m_prev = '0;
    m_old = '0;
    m_lost = 0;
    m_q.delete();
    m_drop = 0;
    m_head = '0;
  endtask

  task automatic model_step();
    logic [CH-1:0] edges;
    bit            dch;
    bit            wrap;
    bit            pop;
    int            inc;
    logic [RW-1:0] r;
    edges = strobe_channels & ~m_prev & strobe_mask;
    dch = (delta_channels != m_old);
    wrap = (m_timer == 0) && counter_operate;
    pop = (m_q.size() > 0) && bus.out_ready;
    inc = 0;
    if (pop) void'(m_q.pop_front());
    if (capture_operate && (dch || edges != 0 || wrap)) begin
      if (dch) r = make_rec(m_timer == 0, 1'b1, m_lost, delta_channels, m_timer);
      else r = make_rec(m_timer == 0, 1'b0, m_lost, edges, m_timer);
      if (m_q.size() < DEPTH) begin
        m_q.push_back(r);
        m_lost = 0;
      end else begin
        inc++;
        m_lost = 1;
      end
      if (dch && edges != 0) begin
        inc++;
        m_lost = 1;
      end
    end
    m_drop = (m_drop + inc > DROP_MAX) ? DROP_MAX : m_drop + inc;
    m_prev = strobe_channels;
    m_old = delta_channels;
    m_timer = reset_counter ? 0 : (m_timer + int'(counter_operate)) % (1 << TW);
    if (m_q.size() > 0) m_head = m_q[0];
  endtask

  task automatic set_in(input logic [CH-1:0] s, input logic [CH-1:0] d, input logic [CH-1:0] m,
                        input bit rc, input bit cop, input bit cap, input bit rdy);
    strobe_channels = s;
    delta_channels = d;
    strobe_mask = m;
    reset_counter = rc;
    counter_operate = cop;
    capture_operate = cap;
    bus.out_ready = rdy;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(m_q.size() > 0));
    check({tag, ".data"}, 32'(bus.out_data), 32'(m_head));
    check({tag, ".level"}, 32'(bus.fifo_level), 32'(m_q.size()));
    check({tag, ".drop"}, 32'(bus.drop_count), 32'(m_drop));
  endtask

  initial begin
    int nwrap;
    logic [CH-1:0] d_cur;

    tbl[0] = '{4'h0, 4'h0, 4'hF, 0, 0, 1, 0, 0, 15'h0000, 0, 0};
    tbl[1] = '{4'h2, 4'h0, 4'hF, 0, 1, 1, 0, 1, 15'h4200, 1, 0};
    tbl[2] = '{4'h2, 4'h0, 4'hF, 0, 1, 1, 1, 0, 15'h4200, 0, 0};
    tbl[3] = '{4'h3, 4'h5, 4'hF, 0, 1, 1, 0, 1, 15'h2502, 1, 1};
    tbl[4] = '{4'h7, 4'h5, 4'hF, 0, 0, 1, 0, 1, 15'h2502, 2, 1};
    tbl[5] = '{4'h0, 4'h5, 4'hF, 0, 0, 1, 1, 1, 15'h1403, 1, 1};
    tbl[6] = '{4'h8, 4'h5, 4'h7, 0, 0, 1, 0, 1, 15'h1403, 1, 1};
    tbl[7] = '{4'h1, 4'h5, 4'hF, 0, 0, 0, 0, 1, 15'h1403, 1, 1};
    tbl[8] = '{4'h1, 4'h5, 4'hF, 1, 1, 1, 0, 1, 15'h1403, 1, 1};
    tbl[9] = '{4'h1, 4'h5, 4'hF, 0, 0, 1, 1, 0, 15'h1403, 0, 1};

    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.data", 32'(bus.out_data), 32'd0);
    check("rst.level", 32'(bus.fifo_level), 32'd0);
    check("rst.drop", 32'(bus.drop_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].s, tbl[i].d, tbl[i].m, tbl[i].rc, tbl[i].cop, tbl[i].cap, tbl[i].rdy);
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d.valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d.data", i), 32'(bus.out_data), 32'(tbl[i].ed));
      check($sformatf("tbl%0d.level", i), 32'(bus.fifo_level), 32'(tbl[i].el));
      check($sformatf("tbl%0d.drop", i), 32'(bus.drop_count), 32'(tbl[i].edr));
    end

    set_in(4'h1, 4'h5, 4'hF, 0, 1, 1, 1);
    cycle("pre_wrap");
    set_in(4'h1, 4'h5, 4'hF, 0, 0, 1, 1);
    cycle("pre_drain");
    for (int i = 0; i < 12; i++) begin
      set_in((i % 2) ? 4'h1 : 4'h0, 4'h5, 4'hF, 0, 0, 1, 0);
      cycle("fill");
    end
    check("fill.level", 32'(bus.fifo_level), 32'd4);
    check("fill.drop", 32'(bus.drop_count), 32'd3);
    set_in(4'h1, 4'h5, 4'hF, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d.data", i), 32'(bus.out_data), 32'h0101);
      cycle("drain");
    end
    check("drain.level", 32'(bus.fifo_level), 32'd0);
    set_in(4'h0, 4'h5, 4'hF, 0, 0, 1, 0);
    cycle("lost_a");
    set_in(4'h1, 4'h5, 4'hF, 0, 0, 1, 0);
    cycle("lost_b");
    check("lost.data", 32'(bus.out_data), 32'h1101);
    check("lost.level", 32'(bus.fifo_level), 32'd1);

    for (int i = 0; i < 6; i++) begin
      set_in((i % 2) ? 4'h1 : 4'h0, 4'h5, 4'hF, 0, 0, 1, 0);
      cycle("refill");
    end
    set_in(4'h0, 4'h5, 4'hF, 0, 0, 1, 0);
    cycle("refill_idle");
    check("full.level", 32'(bus.fifo_level), 32'd4);
    set_in(4'h1, 4'h5, 4'hF, 0, 0, 1, 1);
    cycle("full_pushpop");
    check("pushpop.level", 32'(bus.fifo_level), 32'd4);
    check("pushpop.drop", 32'(bus.drop_count), 32'd3);

    set_in(4'h0, 4'h5, 4'hF, 0, 0, 1, 1);
    cycle("pre_reset");
    set_in(4'h0, 4'h5, 4'hF, 0, 0, 1, 0);
    check("pre_reset.level", 32'(bus.fifo_level), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async.valid", 32'(bus.out_valid), 32'd0);
    check("async.level", 32'(bus.fifo_level), 32'd0);
    check("async.drop", 32'(bus.drop_count), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    set_in(4'h1, 4'h0, 4'hF, 0, 0, 1, 0);
    cycle("post_reset");
    check("post_reset.ts", 32'(bus.out_data[TW-1:0]), 32'd0);
    check("post_reset.data", 32'(bus.out_data), 32'h4100);

    nwrap = 0;
    set_in(4'h1, 4'h0, 4'hF, 0, 1, 1, 1);
    for (int i = 0; i < 600; i++) begin
      cycle("wrap");
      if (bus.out_valid) begin
        nwrap++;
        check("wrap.rec", 32'(bus.out_data), 32'h4000);
      end
    end
    check("wrap.count", 32'(nwrap), 32'd3);

    d_cur = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) d_cur = 4'($urandom);
      set_in(4'($urandom), d_cur,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
             $urandom_range(0, 49) == 0,
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 1) == 1);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/event_tagger_fifo.md
Name: event_tagger_fifo

Overview:
Parametrised successor to the four-channel pulse tagger. Time-stamps strobe rising edges, delta-channel level changes and timer wrap-arounds against a free-running timer. Writes each record into an internal FWFT FIFO drained through a valid/ready handshake, so the downstream readout tolerates back-pressure. Drops are counted and flagged rather than silently lost. Sits between the input conditioning stage and the USB/readout FIFO logic.

Parameters:
CH, 4, number of strobe channels and number of delta channels (each CH wide)
TW, 36, timer width in bits
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 records
DROP_W, 16, width of saturating dropped-record counter
RW, TW+CH+3, record width (derived; do not override)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
strobe_channels  in  CH  strobe inputs, already synchronised to clk
delta_channels  in  CH  level inputs, already synchronised to clk
strobe_mask  in  CH  1 = channel enabled for strobe records
reset_counter  in  1  synchronous timer clear
counter_operate  in  1  timer increment enable
capture_operate  in  1  record write enable
out_data  out  RW  head-of-FIFO record
out_valid  out  1  out_data holds a valid record
out_ready  in  1  consumer accepts record when out_valid && out_ready
fifo_level  out  DEPTH_LOG2+1  current occupancy
drop_count  out  DROP_W  records dropped since reset, saturating at all-ones

Behaviour:
- Record layout, MSB to LSB: {wrap[1], type[1], lost[1], chan[CH], timestamp[TW]}. type: 1 = delta, 0 = strobe/wrap.
- Reset (reset_n low, asynchronous):
  - timer, prev_strobe, old_delta and lost_pending are 0.
  - FIFO is empty; out_valid = 0; out_data = 0; fifo_level = 0; drop_count = 0.
- Timer:
  - Each clk: if reset_counter, timer <= 0; else timer <= timer + counter_operate.
  - Wraps modulo 2**TW with no saturation.
- Event detection (combinational on current inputs vs registers):
  - strobe_edge = strobe_channels & ~prev_strobe & strobe_mask.
  - delta_evt = (delta_channels != old_delta).
  - wrap_evt = (timer == 0) && counter_operate.
  - prev_strobe <= strobe_channels every cycle; old_delta <= delta_channels every cycle.
  - Input tracking updates regardless of capture_operate or FIFO state.
- Priority, at most one record per cycle:
  1. delta_evt: chan = delta_channels, type = 1.
  2. else strobe_edge != 0 or wrap_evt: chan = strobe_edge, type = 0.
  - timestamp = timer value before the edge; wrap = (timer == 0).
  - A strobe edge coincident with a delta event is discarded and counts as one drop.
- Write: a record is written when an event is selected and capture_operate = 1.
  - capture_operate = 0: no write, no drop counted.
  - FIFO full at write (after accounting for a same-cycle pop): record discarded, drop_count increments (saturating), lost_pending <= 1.
  - The next successfully written record carries lost = 1; lost_pending then clears.
- Latency: event present before edge k → record in FIFO at edge k; out_valid = 1 after edge k when the FIFO was empty.
- FIFO:
  - First-word-fall-through.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop when full is allowed: the push succeeds.
  - Pop when empty is ignored.
  - out_data holds its last value when empty (not X).
- reset_counter and capture_operate do not flush the FIFO.

Test Plan:
- CH=4, TW=36: reset, counter_operate=1, strobe_channels=4'b0010 high for 3 cycles at timer=100 → exactly one record: chan=0010, ts=100, type=0, wrap=0, lost=0; out_valid one cycle after the edge.
- delta_channels 0000→0101 while strobe bit0 rises in the same cycle, timer=200 → one delta record: chan=0101, ts=200, type=1; drop_count=1; next strobe record has lost=1.
- TW=8, counter_operate=1, no inputs → wrap record every 256 cycles with ts=0, wrap=1, chan=0000.
- DEPTH_LOG2=2, out_ready=0, 6 strobe edges → fifo_level=4, drop_count=2; raise out_ready → 4 records drain in order, the 5th stored record has lost=1.
- Full FIFO with out_ready=1 and a new edge in the same cycle → push accepted, drop_count unchanged, fifo_level stays 4.
- Assert reset_n mid-stream with 3 records queued → out_valid=0, fifo_level=0 immediately (asynchronous); timer=0 after release.
